// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC ownership, imem handshake,
// IF_pc/IF_inst to IF/ID, stall and redirect handling.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dpc_control,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_reg, pc_d;
  logic [31:0] inst_buf, buf_d;
  logic [31:0] kill_addr, kill_d;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        br_lsb_unused;

  assign tgt           = {br_target[31:2], 2'b00};
  assign pc_inc        = pc_reg + 32'd4;
  assign br_lsb_unused = ^br_target[1:0];
  assign IF_pc         = pc_reg;

  // State, PC, held instruction and killed-request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      pc_reg    <= RESET_PC;
      inst_buf  <= BUBBLE;
      kill_addr <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_reg    <= pc_d;
      inst_buf  <= buf_d;
      kill_addr <= kill_d;
    end
  end

  // Next state and outputs; redirect beats stall everywhere
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_reg;
    buf_d     = inst_buf;
    kill_d    = kill_addr;
    imem_req  = 1'b1;
    imem_addr = pc_reg;
    IF_inst   = BUBBLE;
    unique case (state_q)
      S_WAIT: begin
        if (imem_ack) begin
          if (br_taken) begin
            pc_d = tgt;
          end else if (dpc_control) begin
            IF_inst = imem_rdata;
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            IF_inst = imem_rdata;
            pc_d    = pc_inc;
          end
        end else if (br_taken) begin
          kill_d  = pc_reg;
          pc_d    = tgt;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        imem_addr = kill_addr;
        if (br_taken) pc_d = tgt;
        if (imem_ack) state_d = S_WAIT;
      end
      S_HOLD: begin
        imem_req = 1'b0;
        IF_inst  = br_taken ? BUBBLE : inst_buf;
        if (br_taken) begin
          pc_d    = tgt;
          state_d = S_WAIT;
        end else if (!dpc_control) begin
          pc_d    = pc_inc;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: per-cycle
// expectations queued per scenario and popped each cycle.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        dpc_control;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        dpc;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t sb[$];

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dpc_control (dpc_control),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .IF_pc       (IF_pc),
    .IF_inst     (IF_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic dpc, logic br, logic [31:0] tgt,
    logic ack, logic [31:0] rd,
    logic req, logic [31:0] addr,
    logic [31:0] pc, logic [31:0] inst);
    vec_t v;
    v.dpc = dpc; v.br = br; v.tgt = tgt;
    v.ack = ack; v.rd = rd; v.req = req;
    v.addr = addr; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    dpc_control = v.dpc;
    br_taken    = v.br;
    br_target   = v.tgt;
    imem_ack    = v.ack;
    imem_rdata  = v.rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dpc_control = 0; br_taken = 0; br_target = 0;
    imem_ack = 0; imem_rdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dpc_control = 0; br_taken = 0; br_target = 0;
    imem_ack = 0; imem_rdata = 0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
        IF_pc !== 32'h0 || IF_inst !== 32'h0) begin
      bad++;
      $display("FAIL reset: req=%b addr=%h pc=%h inst=%h want 1/0/0/0",
               imem_req, imem_addr, IF_pc, IF_inst);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      sb.push_back(mk(0, 0, 0, 1, a, 1, a, a, a));
    end
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL zero_wait: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'h1234_5678, 1, 0, 0, 32'h1234_5678));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 4, 4, 0));
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL latency: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = 32'hC0DE_0008;
    do_reset();
    sb.push_back(mk(0, 0, 0, 1, 32'h100, 1, 0, 0, 32'h100));
    sb.push_back(mk(0, 0, 0, 1, 32'h104, 1, 4, 4, 32'h104));
    sb.push_back(mk(1, 0, 0, 1, w, 1, 8, 8, w));
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, w));
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, w));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, w));
    sb.push_back(mk(0, 0, 0, 1, 32'hC, 1, 12, 12, 32'hC));
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL stall: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_kill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      sb.push_back(mk(0, 0, 0, 1, a, 1, a, a, a));
    end
    sb.push_back(mk(0, 1, 32'h103, 0, 0, 1, 16, 16, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 16, 32'h100, 0));
    sb.push_back(mk(0, 1, 32'h202, 0, 0, 1, 16, 32'h100, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'hDEAD, 1, 16, 32'h200, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 32'h200, 32'h200, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'hAAAA_0200, 1, 32'h200, 32'h200,
                    32'hAAAA_0200));
    sb.push_back(mk(0, 0, 0, 1, 32'h55, 1, 32'h204, 32'h204, 32'h55));
    sb.push_back(mk(0, 1, 32'h300, 1, 32'h66, 1, 32'h208, 32'h208, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'h77, 1, 32'h300, 32'h300, 32'h77));
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL kill: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    sb.push_back(mk(1, 0, 0, 1, 32'h11, 1, 0, 0, 32'h11));
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h11));
    sb.push_back(mk(1, 1, 32'h41, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'h22, 1, 32'h40, 32'h40, 32'h22));
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL hold_redirect: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] top;
    top = 32'hFFFF_FFFC;
    do_reset();
    sb.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 32'h9, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1, 32'h5, 1, top, top, 32'h5));
    sb.push_back(mk(0, 0, 0, 1, 32'h6, 1, 0, 0, 32'h6));
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      total++;
      if (imem_req !== v.req || (v.req && imem_addr !== v.addr) ||
          IF_pc !== v.pc || IF_inst !== v.inst) begin
        bad++;
        $display("FAIL wrap: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
                 imem_req, imem_addr, IF_pc, IF_inst,
                 v.req, v.addr, v.pc, v.inst);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v;
    do_reset();
    drive(mk(0, 0, 0, 1, 32'h1, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 1, 32'h2, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL async_pending: req=%b addr=%h want 1/00000008",
               imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
        IF_pc !== 32'h0 || IF_inst !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: req=%b addr=%h pc=%h inst=%h want 1/0/0/0",
               imem_req, imem_addr, IF_pc, IF_inst);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(0, 0, 0, 1, 32'h77, 1, 0, 0, 32'h77);
    drive(v);
    total++;
    if (imem_req !== v.req || imem_addr !== v.addr ||
        IF_pc !== v.pc || IF_inst !== v.inst) begin
      bad++;
      $display("FAIL async_restart: req=%b addr=%h pc=%h inst=%h want %b/%h/%h/%h",
               imem_req, imem_addr, IF_pc, IF_inst,
               v.req, v.addr, v.pc, v.inst);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dpc_control = 0; br_taken = 0; br_target = 0;
    imem_ack = 0; imem_rdata = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_kill();
    test_hold_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
